vespa_dftpulse_seq: RTL and testbench
=====================================

# vespa_dftpulse_seq

Upstream sequencer for the VESPA DFT pulse stage: it generates the `start`/`stop` control pair that the downstream pulse gate combines as `pulse = start & ~stop`. On an `arm` request it waits a programmable delay, then emits a programmable number of pulses of programmable width and gap. Edges are break-before-make, so `start` and `stop` never change in the same cycle and the downstream gate stays glitch-free.

## Interface
- `CNT_W`, default 8: width of the delay, width, gap and count fields and their internal counters.
- `clk`  input  1  sequencer clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `arm`  input  1  request a pulse train; sampled only in IDLE.
- `abort`  input  1  synchronous cancel of the current train.
- `cfg_delay`  input  CNT_W  cycles from the arm acceptance to SETUP.
- `cfg_width`  input  CNT_W  ACTIVE cycles per pulse; 0 is treated as 1.
- `cfg_gap`  input  CNT_W  GAP cycles between pulses; 0 is treated as 1.
- `cfg_count`  input  CNT_W  number of pulses; 0 means arm is ignored.
- `start`  output  1  to the pulse-gate `start` input.
- `stop`  output  1  to the pulse-gate `stop` input.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle strobe on normal completion.
- `remaining`  output  CNT_W  pulses not yet started.
- `CELV`, `CELG`, `CELSUB`  input  1  supply, ground and substrate pins; passed through to the cells with no logic function.

All outputs are registered.

## Operation
- **Reset values:** state=IDLE, `start`=0, `stop`=1, `busy`=0, `done`=0, `remaining`=0, all counters 0.
- **Arm acceptance:** arm is accepted when `arm`=1 and `cfg_count`≠0 in IDLE. On acceptance the block latches all cfg fields and loads `remaining`=`cfg_count`. cfg changes after acceptance are ignored. `arm` outside IDLE is ignored.
- **States and per-state outputs:**
  - IDLE: `start`=0, `stop`=1.
  - DELAY: `start`=0, `stop`=1; lasts `cfg_delay` cycles; skipped entirely if `cfg_delay`=0.
  - SETUP: `start`=1, `stop`=1; one cycle; `remaining` decrements on entry.
  - ACTIVE: `start`=1, `stop`=0; lasts W cycles (W = max(`cfg_width`, 1)).
  - HOLD: `start`=1, `stop`=1; one cycle.
  - GAP: `start`=0, `stop`=1; lasts max(`cfg_gap`, 1) cycles; then SETUP.
  - DONE: `start`=0, `stop`=1, `done`=1; one cycle; then IDLE.
- **Transitions:** IDLE→DELAY or SETUP; DELAY→SETUP; SETUP→ACTIVE; ACTIVE→HOLD; HOLD→GAP if `remaining`≠0, else DONE.
- **Abort:**
  - Applies in any non-IDLE state.
  - From ACTIVE: go to HOLD, then IDLE, so `stop` rises before `start` falls.
  - From SETUP or HOLD: go directly to IDLE with `start`=0, `stop`=1. This is legal because `stop` is already 1.
  - From any other state: go to IDLE.
  - `done` does not pulse on abort; `remaining` is cleared to 0.
  - `abort` takes priority over every other transition in the same cycle.
- **Reset mid-train:** outputs go to their reset values immediately (asynchronously); any pulse in progress is truncated.
- **Counter arithmetic:** counters count down from the loaded value and are compared against 1. No count wraps; the maximum is 2^CNT_W−1 cycles per phase.

## Timing
- Outputs reflect state in the cycle after the clock edge that enters that state.
- With arm accepted at cycle 0 and delay D:
  - DELAY occupies cycles 1..D.
  - SETUP occupies cycle D+1.
  - ACTIVE occupies cycles D+2..D+1+W.
  - HOLD occupies cycle D+2+W.
- With N pulses, gap width Gw = max(`cfg_gap`, 1), and period P = W+2+Gw, pulse k (0-based) has ACTIVE starting at cycle D+2+k·P.
- `done` occurs at cycle D+3+W+(N−1)·P. IDLE follows one cycle later.
- The downstream pulse is high for exactly W cycles per pulse.
- `busy` rises in the cycle after acceptance and falls when IDLE is re-entered.
- Back-to-back trains: the earliest new acceptance is the first IDLE cycle after DONE.
- `start` and `stop` never toggle in the same cycle, including on abort.

## Test plan
- **Reset:** hold `rst_n`=0 → `start`=0, `stop`=1, `busy`=0, `done`=0, `remaining`=0. Assert reset mid-ACTIVE → outputs return to these values without waiting for a clock.
- **Single pulse:** D=2, W=3, N=1, arm at cycle 0 → DELAY cycles 1–2; SETUP at 3; `start`=1,`stop`=0 on cycles 4–6; HOLD at 7; `done` at 8; `busy` high on cycles 1–8.
- **Pulse train:** D=0, W=2, G=1, N=3 → ACTIVE windows start at cycles 2, 7, 12; `done` at 15; `remaining` reads 2, 1, 0 after each SETUP.
- **Zero fields:** `cfg_count`=0 with `arm` → block stays IDLE, `busy`=0. `cfg_width`=0 and `cfg_gap`=0 → 1-cycle ACTIVE and 1-cycle GAP.
- **Abort in ACTIVE:** abort on the second ACTIVE cycle of W=5 → HOLD (`start`=1,`stop`=1) next cycle, then IDLE; no `done`; `remaining`=0; `start` and `stop` never change in the same cycle.
- **Ignored requests:** `arm` during DELAY, and cfg changes after acceptance → no effect on timing. Simultaneous `arm`+`abort` in IDLE → arm accepted (`abort` has no effect in IDLE).

Source files
------------

// File: rtl/vespa_dftpulse_seq.sv
// vespa_dftpulse_seq: start/stop sequencer for the VESPA DFT pulse gate.
// After an accepted arm it waits a delay, then emits a train of pulses with
// a programmable width, gap and count. Every state change alters at most one
// of start/stop, so the downstream gate (start & ~stop) never glitches.
module vespa_dftpulse_seq #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             start,
    output logic             stop,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining,
    input  logic             CELV,
    input  logic             CELG,
    input  logic             CELSUB
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StDelay  = 3'd1;
    localparam logic [2:0] StSetup  = 3'd2;
    localparam logic [2:0] StActive = 3'd3;
    localparam logic [2:0] StHold   = 3'd4;
    localparam logic [2:0] StGap    = 3'd5;
    localparam logic [2:0] StDone   = 3'd6;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    // Supply pins carry no logic function.
    logic unused_supply;
    assign unused_supply = ^{CELV, CELG, CELSUB};

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    // Set when an abort hit ACTIVE: the following HOLD exits to IDLE, not DONE.
    logic             kill_q, kill_d;
    logic             start_d, stop_d, busy_d, done_d;

    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CntOne : v;
    endfunction

    // Next-state logic: phase sequencing, counters and abort override.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        gap_d   = gap_q;
        rem_d   = rem_q;
        kill_d  = kill_q;

        case (state_q)
            StIdle: begin
                kill_d = 1'b0;
                if (arm && (cfg_count != '0)) begin
                    width_d = at_least_one(cfg_width);
                    gap_d   = at_least_one(cfg_gap);
                    if (cfg_delay != '0) begin
                        state_d = StDelay;
                        cnt_d   = cfg_delay;
                        rem_d   = cfg_count;
                    end else begin
                        state_d = StSetup;
                        cnt_d   = '0;
                        rem_d   = cfg_count - CntOne;
                    end
                end
            end
            StDelay: begin
                if (cnt_q <= CntOne) begin
                    state_d = StSetup;
                    cnt_d   = '0;
                    rem_d   = rem_q - CntOne;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StSetup: begin
                state_d = StActive;
                cnt_d   = width_q;
            end
            StActive: begin
                if (cnt_q <= CntOne) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StHold: begin
                if (kill_q) begin
                    state_d = StIdle;
                end else if (rem_q != '0) begin
                    state_d = StGap;
                    cnt_d   = gap_q;
                end else begin
                    state_d = StDone;
                end
            end
            StGap: begin
                if (cnt_q <= CntOne) begin
                    state_d = StSetup;
                    cnt_d   = '0;
                    rem_d   = rem_q - CntOne;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                rem_d   = '0;
            end
        endcase

        // ACTIVE must pass through HOLD so stop rises before start falls.
        if (abort && (state_q != StIdle)) begin
            rem_d = '0;
            cnt_d = '0;
            if (state_q == StActive) begin
                state_d = StHold;
                kill_d  = 1'b1;
            end else begin
                state_d = StIdle;
                kill_d  = 1'b0;
            end
        end
    end

    // Output decode from the next state, so registered outputs track the state.
    always_comb begin
        start_d = (state_d == StSetup) || (state_d == StActive) || (state_d == StHold);
        stop_d  = (state_d != StActive);
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
    end

    // State and registered outputs; async reset truncates any pulse in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            width_q <= '0;
            gap_q   <= '0;
            rem_q   <= '0;
            kill_q  <= 1'b0;
            start   <= 1'b0;
            stop    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            gap_q   <= gap_d;
            rem_q   <= rem_d;
            kill_q  <= kill_d;
            start   <= start_d;
            stop    <= stop_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    assign remaining = rem_q;

endmodule

// File: tb/tb_vespa_dftpulse_seq.sv
// Self-checking bench for vespa_dftpulse_seq: table of trains with hand-derived
// totals, hand-written corner sequences, and random trains against a timeline
// model built from the phase-length arithmetic.
module tb_vespa_dftpulse_seq;

    localparam int CW = 8;

    // Model phases (bench-local numbering).
    localparam int PIdle   = 0;
    localparam int PDelay  = 1;
    localparam int PSetup  = 2;
    localparam int PActive = 3;
    localparam int PHold   = 4;
    localparam int PGap    = 5;
    localparam int PDone   = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] cfg_delay = '0;
    logic [CW-1:0] cfg_width = '0;
    logic [CW-1:0] cfg_gap = '0;
    logic [CW-1:0] cfg_count = '0;
    logic          start, stop, busy, done;
    logic [CW-1:0] remaining;

    int vectors = 0;
    int miscompares = 0;

    vespa_dftpulse_seq #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .abort     (abort),
        .cfg_delay (cfg_delay),
        .cfg_width (cfg_width),
        .cfg_gap   (cfg_gap),
        .cfg_count (cfg_count),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .CELV      (1'b1),
        .CELG      (1'b0),
        .CELSUB    (1'b0)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d; int w; int g; int n; int ta;
        int exp_done; int exp_act; int exp_busy;
    } vec_t;

    vec_t tbl[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW+3:0] got_vec();
        return {start, stop, busy, done, remaining};
    endfunction

    function automatic logic [CW+3:0] mk_vec(input logic s, input logic p, input logic b,
                                             input logic dn, input int rem);
        logic [CW-1:0] r;
        r = CW'(rem);
        return {s, p, b, dn, r};
    endfunction

    task automatic chk_vec(input string name, input int t, input logic [CW+3:0] got,
                           input logic [CW+3:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d got start/stop/busy/done/rem=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                     name, t, got[CW+3], got[CW+2], got[CW+1], got[CW], got[CW-1:0],
                     exp[CW+3], exp[CW+2], exp[CW+1], exp[CW], exp[CW-1:0]);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Cycle of the done strobe, counted from the acceptance cycle (0 = no train).
    function automatic int train_len(input int d, input int w, input int g, input int n);
        if (n == 0) return 0;
        return d + 3 + eff(w) + (n - 1) * (eff(w) + 2 + eff(g));
    endfunction

    // Phase and remaining count at cycle t of an uninterrupted train.
    function automatic void ref_plain(input int t, input int d, input int w, input int g,
                                      input int n, output int ph, output int rem);
        int len, wq, per, u, k, r;
        len = train_len(d, w, g, n);
        wq  = eff(w);
        per = wq + 2 + eff(g);
        if (n == 0 || t < 1 || t > len) begin
            ph = PIdle; rem = 0;
        end else if (t == len) begin
            ph = PDone; rem = 0;
        end else if (t <= d) begin
            ph = PDelay; rem = n;
        end else begin
            u = t - d - 1;
            k = u / per;
            r = u % per;
            rem = n - 1 - k;
            if (r == 0)           ph = PSetup;
            else if (r <= wq)     ph = PActive;
            else if (r == wq + 1) ph = PHold;
            else                  ph = PGap;
        end
    endfunction

    // Same, with an abort driven during cycle ta (0 = none).
    function automatic void ref_model(input int t, input int d, input int w, input int g,
                                      input int n, input int ta, output int ph,
                                      output int rem);
        int pa, ra;
        if (ta > 0 && t > ta) begin
            ref_plain(ta, d, w, g, n, pa, ra);
            if (pa == PIdle) begin
                ref_plain(t, d, w, g, n, ph, rem);
            end else if (pa == PActive && t == ta + 1) begin
                ph = PHold; rem = 0;
            end else begin
                ph = PIdle; rem = 0;
            end
        end else begin
            ref_plain(t, d, w, g, n, ph, rem);
        end
    endfunction

    function automatic logic [CW+3:0] phase_vec(input int ph, input int rem);
        return mk_vec(ph == PSetup || ph == PActive || ph == PHold, ph != PActive,
                      ph != PIdle, ph == PDone, rem);
    endfunction

    // Arms one train in the current cycle and checks every following cycle against
    // the model; cfg and arm are scrambled while the train runs to prove they are ignored.
    task automatic run_train(input string name, input int d, input int w, input int g,
                             input int n, input int ta, output int done_at,
                             output int act_cnt, output int busy_cnt, output int bbm_bad);
        int len, ph, rem, nph, nrem;
        logic ps, pp;
        bit fin;
        len = train_len(d, w, g, n);
        cfg_delay = CW'(d);
        cfg_width = CW'(w);
        cfg_gap   = CW'(g);
        cfg_count = CW'(n);
        arm   = 1'b1;
        abort = 1'b0;
        ps = start;
        pp = stop;
        done_at = 0; act_cnt = 0; busy_cnt = 0; bbm_bad = 0;
        fin = 1'b0;
        for (int t = 1; t <= len + 4 && !fin; t++) begin
            step();
            arm   = 1'b0;
            abort = 1'b0;
            ref_model(t, d, w, g, n, ta, ph, rem);
            chk_vec(name, t, got_vec(), phase_vec(ph, rem));
            if (start && !stop) act_cnt++;
            if (busy) busy_cnt++;
            if (done && done_at == 0) done_at = t;
            if (start != ps && stop != pp) bbm_bad++;
            ps = start;
            pp = stop;
            if (ph == PIdle) begin
                fin = 1'b1;
            end else begin
                // State at the coming edge is non-IDLE, so arm must be ignored.
                ref_model(t + 1, d, w, g, n, ta, nph, nrem);
                cfg_delay = CW'($urandom);
                cfg_width = CW'($urandom);
                cfg_gap   = CW'($urandom);
                cfg_count = CW'($urandom);
                arm   = 1'($urandom);
                abort = (t == ta);
            end
        end
        arm   = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int da, ac, bc, bb, d, w, g, n, ta, len;

        //          d    w  g  n  ta  done act busy
        tbl[0] = '{ 2,   3, 0, 1, 0,   8,  3,   8};
        tbl[1] = '{ 0,   2, 1, 3, 0,  15,  6,  15};
        tbl[2] = '{ 0,   0, 0, 2, 0,   8,  2,   8};
        tbl[3] = '{ 5,   1, 3, 2, 0,  15,  2,  15};
        tbl[4] = '{ 1,   4, 2, 1, 0,   8,  4,   8};
        tbl[5] = '{ 0,   1, 0, 0, 0,   0,  0,   0};
        tbl[6] = '{ 0,   5, 2, 2, 3,   0,  2,   4};
        tbl[7] = '{255,  1, 0, 1, 0, 259,  1, 259};

        rst_n = 1'b0;
        repeat (2) step();
        chk_vec("reset_held", 0, got_vec(), mk_vec(1'b0, 1'b1, 1'b0, 1'b0, 0));
        rst_n = 1'b1;
        step();
        chk_vec("idle_after_reset", 0, got_vec(), mk_vec(1'b0, 1'b1, 1'b0, 1'b0, 0));

        foreach (tbl[i]) begin
            run_train($sformatf("tbl%0d", i), tbl[i].d, tbl[i].w, tbl[i].g, tbl[i].n,
                      tbl[i].ta, da, ac, bc, bb);
            chk_int($sformatf("tbl%0d_done_cycle", i), da, tbl[i].exp_done);
            chk_int($sformatf("tbl%0d_pulse_cycles", i), ac, tbl[i].exp_act);
            chk_int($sformatf("tbl%0d_busy_cycles", i), bc, tbl[i].exp_busy);
            chk_int($sformatf("tbl%0d_bbm_violations", i), bb, 0);
        end

        // arm + abort together in IDLE: arm wins, train runs normally.
        cfg_delay = 0; cfg_width = 1; cfg_gap = 1; cfg_count = 1;
        arm = 1'b1; abort = 1'b1;
        step();
        arm = 1'b0; abort = 1'b0;
        chk_vec("arm_abort_idle", 1, got_vec(), mk_vec(1'b1, 1'b1, 1'b1, 1'b0, 0));
        step();
        chk_vec("arm_abort_idle", 2, got_vec(), mk_vec(1'b1, 1'b0, 1'b1, 1'b0, 0));
        step();
        chk_vec("arm_abort_idle", 3, got_vec(), mk_vec(1'b1, 1'b1, 1'b1, 1'b0, 0));
        step();
        chk_vec("arm_abort_idle", 4, got_vec(), mk_vec(1'b0, 1'b1, 1'b1, 1'b1, 0));
        step();
        chk_vec("arm_abort_idle", 5, got_vec(), mk_vec(1'b0, 1'b1, 1'b0, 1'b0, 0));

        // Reset asserted mid-ACTIVE takes effect without a clock edge.
        cfg_delay = 0; cfg_width = 5; cfg_gap = 1; cfg_count = 2;
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        chk_vec("pre_reset_active", 2, got_vec(), mk_vec(1'b1, 1'b0, 1'b1, 1'b0, 1));
        #2 rst_n = 1'b0;
        #1;
        chk_vec("async_reset", 2, got_vec(), mk_vec(1'b0, 1'b1, 1'b0, 1'b0, 0));
        step();
        rst_n = 1'b1;
        step();
        chk_vec("idle_after_mid_reset", 0, got_vec(), mk_vec(1'b0, 1'b1, 1'b0, 1'b0, 0));

        // Random trains, some aborted, against the timeline model.
        for (int i = 0; i < 30; i++) begin
            d = $urandom_range(0, 6);
            w = $urandom_range(0, 6);
            g = $urandom_range(0, 6);
            n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            len = train_len(d, w, g, n);
            ta = (len > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0;
            run_train($sformatf("rnd%0d", i), d, w, g, n, ta, da, ac, bc, bb);
            chk_int($sformatf("rnd%0d_bbm_violations", i), bb, 0);
            if (ta == 0) begin
                chk_int($sformatf("rnd%0d_pulse_cycles", i), ac, n * eff(w));
            end
            repeat ($urandom_range(0, 2)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
